spi_ram: RTL
============

SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of 8-bit memory words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, meaning the address width; MEM_DEPTH = 2**ADDR_SIZE and ADDR_SIZE <= 8.
REQ-003 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port din, input, 10 bits, the command word from the SPI slave: din[9:8] is the opcode and din[7:0] is the payload.
REQ-006 The block SHALL have port rx_valid, input, 1 bit; when high, din is valid this cycle.
REQ-007 The block SHALL have port dout, output, 8 bits, the read data sent to the SPI slave tx_data.
REQ-008 The block SHALL have port tx_valid, output, 1 bit, a one-cycle pulse qualifying dout.
REQ-009 The block SHALL have port err, output, 1 bit, a one-cycle pulse flagging an out-of-sequence command.

Function
REQ-010 The block SHALL act on din only in cycles where rx_valid=1; it SHALL ignore din otherwise.
REQ-011 The opcodes SHALL be decoded as follows:
- 00 = WR_ADDR
- 01 = WR_DATA
- 10 = RD_ADDR
- 11 = RD_DATA
REQ-012 The block SHALL hold two 1-bit armed flags, wr_arm and rd_arm, plus address registers wr_ptr and rd_ptr, each ADDR_SIZE bits wide.
REQ-013 On WR_ADDR, the block SHALL set wr_ptr <= din[ADDR_SIZE-1:0] and wr_arm <= 1; any din bits above ADDR_SIZE SHALL be ignored.
REQ-014 On WR_DATA with wr_arm=1, the block SHALL set mem[wr_ptr] <= din[7:0] and wr_ptr <= wr_ptr+1; wr_arm SHALL stay 1.
REQ-015 On WR_DATA with wr_arm=0, the block SHALL leave the memory unchanged and pulse err the next cycle.
REQ-016 On RD_ADDR, the block SHALL set rd_ptr <= din[ADDR_SIZE-1:0] and rd_arm <= 1.
REQ-017 On RD_DATA with rd_arm=1, the block SHALL register dout <= mem[rd_ptr] and rd_ptr <= rd_ptr+1, and pulse tx_valid for exactly one cycle; dout and tx_valid SHALL become visible on the cycle after the rx_valid cycle (latency 1).
REQ-018 On RD_DATA with rd_arm=0, dout SHALL hold its value, tx_valid SHALL stay 0, and err SHALL pulse the next cycle.
REQ-019 Pointer increments SHALL wrap modulo MEM_DEPTH: MEM_DEPTH-1 -> 0.
REQ-020 dout SHALL hold its last read value between reads; tx_valid and err SHALL be 0 in every cycle not named above.
REQ-021 The write and read paths SHALL be independent; a WR_* command SHALL NOT change rd_ptr or rd_arm, and an RD_* command SHALL NOT change wr_ptr or wr_arm.
REQ-022 A read of the location written by the immediately preceding command SHALL return the newly written value (write-then-read ordering).
REQ-023 Back-to-back rx_valid in consecutive cycles SHALL each be processed with no loss.

Reset
REQ-024 While rst_n=0, the following SHALL hold:
- dout = 8'h00, tx_valid = 0, err = 0
- wr_ptr = 0, rd_ptr = 0, wr_arm = 0, rd_arm = 0
REQ-025 Reset SHALL NOT initialise memory contents.
REQ-026 A reset asserted mid-sequence SHALL disarm both paths, so the first RD_DATA or WR_DATA after reset produces err.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Write sequence: 0x0A5 (WR_ADDR 0xA5), then 0x13C (WR_DATA 0x3C), then 0x2A5 (RD_ADDR 0xA5), then 0x3xx (RD_DATA) -> dout=0x3C and a 1-cycle tx_valid one cycle after the RD_DATA rx_valid.
- Auto-increment with wrap: WR_ADDR 0xFF, then WR_DATA 0x11, then WR_DATA 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22; the same wrap SHALL be checked on reads.
- Out of sequence after reset: RD_DATA -> err pulse, tx_valid=0, dout=0x00; WR_DATA 0x55 -> err pulse and no memory change (verified by a later read).
- Path independence: WR_ADDR 0x10, then RD_ADDR 0x20, then WR_DATA 0x77, then RD_DATA -> returns mem[0x20], not 0x77, and mem[0x10]=0x77.
- Back-to-back: four consecutive RD_DATA after RD_ADDR 0x00 -> four tx_valid pulses in consecutive cycles with dout = mem[0..3].
- Mid-operation reset: rst_n pulsed low between WR_ADDR and WR_DATA -> outputs zero while low, and the following WR_DATA raises err.

Source files
------------

// File: rtl/spi_ram.sv
// Byte-wide RAM behind an SPI slave: 10-bit command words drive independent
// write and read pointers, each armed by its own address command.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 wr_arm;
  logic                 rd_arm;
  logic [1:0]           op;
  logic                 wr_en;

  assign op = din[9:8];

  always_comb begin
    wr_en = 1'b0;
    if (rx_valid && op == WR_DATA && wr_arm)
      wr_en = 1'b1;
  end

  // Memory deliberately has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= din[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_arm   <= 1'b0;
      rd_arm   <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      err      <= 1'b0;
      if (rx_valid) begin
        case (op)
          WR_ADDR: begin
            wr_ptr <= din[ADDR_SIZE-1:0];
            wr_arm <= 1'b1;
          end
          WR_DATA: begin
            if (wr_arm)
              wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            else
              err <= 1'b1;
          end
          RD_ADDR: begin
            rd_ptr <= din[ADDR_SIZE-1:0];
            rd_arm <= 1'b1;
          end
          default: begin
            if (rd_arm) begin
              dout     <= mem[rd_ptr];
              rd_ptr   <= rd_ptr + ADDR_SIZE'(1);
              tx_valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
